// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master receive path.
package spi_master_pkg;

  localparam int SPI_WORD_W = 32;
  localparam int SPI_CNT_W  = 16;

  typedef enum logic {
    SPI_STD  = 1'b0,
    SPI_QUAD = 1'b1
  } spi_mode_e;

  // Append one beat of samples to the shift register, MSB-first.
  function automatic logic [SPI_WORD_W-1:0] spi_shift_in(
    input logic [SPI_WORD_W-1:0] sh,
    input spi_mode_e             mode,
    input logic [3:0]            sdi
  );
    logic [SPI_WORD_W-1:0] res;
    case (mode)
      SPI_QUAD: res = {sh[SPI_WORD_W-5:0], sdi};
      SPI_STD:  res = {sh[SPI_WORD_W-2:0], sdi[0]};
      default:  res = {sh[SPI_WORD_W-2:0], sdi[0]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spi_rx_outreg.sv
// Single-entry valid/ready holding register for received words, with a sticky
// overflow flag raised when a completed word arrives while the slot is still full.
module spi_rx_outreg
  import spi_master_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  word_valid_i,
  input  logic [SPI_WORD_W-1:0] word_i,
  input  logic                  ready_i,
  input  logic                  overflow_clr_i,
  output logic [SPI_WORD_W-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  overflow_o
);

  logic [SPI_WORD_W-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  accept_s;
  logic                  drop_s;

  // Next-state: load when the slot is free or being emptied this cycle, otherwise drop.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    accept_s = word_valid_i & (~valid_q | ready_i);
    drop_s   = word_valid_i & valid_q & ~ready_i;
    if (accept_s) begin
      data_d  = word_i;
      valid_d = 1'b1;
    end else if (valid_q & ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (overflow_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Holding register and overflow flag state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q  <= {SPI_WORD_W{1'b0}};
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/spi_master_rx.sv
// SPI master receive datapath: samples sdi on rx_edge beats (1 or 4 bits per beat),
// packs MSB-first into 32-bit words and delivers them through a holding register.
module spi_master_rx
  import spi_master_pkg::*;
#(
  parameter int CNT_W    = SPI_CNT_W,
  parameter int RST_TRGT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  rx_edge,
  input  logic                  sdi0,
  input  logic                  sdi1,
  input  logic                  sdi2,
  input  logic                  sdi3,
  input  logic                  en_quad_in,
  input  logic [CNT_W-1:0]      counter_in,
  input  logic                  counter_in_upd,
  output logic                  rx_done,
  output logic [SPI_WORD_W-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  rx_stall,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  logic [CNT_W-1:0]      counter_q, counter_d;
  logic [CNT_W-1:0]      trgt_q, trgt_d;
  logic [SPI_WORD_W-1:0] shift_q, shift_d;
  logic                  running_q, running_d;

  spi_mode_e             mode_s;
  logic                  beat_s;
  logic                  step_s;
  logic                  last_s;
  logic                  wb_s;
  logic [CNT_W-1:0]      load_trgt_s;
  logic [SPI_WORD_W-1:0] shift_in_s;

  assign mode_s     = spi_mode_e'(en_quad_in);
  assign beat_s     = en & rx_edge;
  // A beat coinciding with a target load is discarded.
  assign step_s     = beat_s & ~counter_in_upd;
  assign last_s     = (counter_q == (trgt_q - CNT_W'(1)));
  assign shift_in_s = spi_shift_in(shift_q, mode_s, {sdi3, sdi2, sdi1, sdi0});

  // Word boundary and load target depend on how many bits each beat carries.
  always_comb begin
    wb_s        = last_s;
    load_trgt_s = counter_in;
    case (mode_s)
      SPI_QUAD: begin
        wb_s        = last_s | (counter_q[2:0] == 3'd7);
        load_trgt_s = counter_in >> 2;
      end
      SPI_STD: begin
        wb_s        = last_s | (counter_q[4:0] == 5'd31);
        load_trgt_s = counter_in;
      end
      default: begin
        wb_s        = last_s;
        load_trgt_s = counter_in;
      end
    endcase
  end

  // Counter, target and shift register next-state; shift clears at each word boundary.
  always_comb begin
    counter_d = counter_q;
    trgt_d    = trgt_q;
    shift_d   = shift_q;
    running_d = running_q;
    if (counter_in_upd) begin
      trgt_d    = (load_trgt_s == {CNT_W{1'b0}}) ? CNT_W'(1) : load_trgt_s;
      counter_d = {CNT_W{1'b0}};
      shift_d   = {SPI_WORD_W{1'b0}};
      running_d = 1'b1;
    end else if (beat_s) begin
      shift_d   = wb_s ? {SPI_WORD_W{1'b0}} : shift_in_s;
      counter_d = last_s ? {CNT_W{1'b0}} : (counter_q + CNT_W'(1));
      running_d = last_s ? 1'b0 : running_q;
    end else begin
      counter_d = counter_q;
    end
  end

  // Transfer state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counter_q <= {CNT_W{1'b0}};
      trgt_q    <= CNT_W'(RST_TRGT);
      shift_q   <= {SPI_WORD_W{1'b0}};
      running_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      trgt_q    <= trgt_d;
      shift_q   <= shift_d;
      running_q <= running_d;
    end
  end

  assign rx_done  = step_s & last_s;
  assign rx_stall = running_q & data_valid & ~data_ready & wb_s;

  spi_rx_outreg u_outreg (
    .clk            (clk),
    .rstn           (rstn),
    .word_valid_i   (step_s & wb_s),
    .word_i         (shift_in_s),
    .ready_i        (data_ready),
    .overflow_clr_i (overflow_clr),
    .data_o         (data),
    .data_valid_o   (data_valid),
    .overflow_o     (overflow)
  );

endmodule
